// File: rtl/jpd_pkg.sv
// Shared types and constants for the joypad serial scanner.
package jpd_pkg;

    localparam int unsigned JPD_VEC_W    = 10;
    localparam int unsigned JPD_BIT_W    = 3;
    localparam int unsigned JPD_SCAN_LEN = 17;

    localparam int unsigned JPD_A      = 0;
    localparam int unsigned JPD_B      = 1;
    localparam int unsigned JPD_SELECT = 2;
    localparam int unsigned JPD_START  = 3;
    localparam int unsigned JPD_UP     = 4;
    localparam int unsigned JPD_DOWN   = 5;
    localparam int unsigned JPD_LEFT   = 6;
    localparam int unsigned JPD_RIGHT  = 7;
    localparam int unsigned JPD_TB_A   = 8;
    localparam int unsigned JPD_TB_B   = 9;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH0 = 3'd1,
        LATCH1 = 3'd2,
        S0     = 3'd3,
        LO     = 3'd4,
        HI     = 3'd5,
        CMP    = 3'd6
    } jpd_state_e;

endpackage

// File: rtl/jpd_tick_gen.sv
// Free-running tick divider plus the scan period counter that paces scan starts.
module jpd_tick_gen #(
    parameter int unsigned TICK_DIV   = 108,
    parameter int unsigned SCAN_TICKS = 2778
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick,
    output logic o_scan_start
);

    localparam int unsigned DIV_W = $clog2(TICK_DIV);
    localparam int unsigned PER_W = $clog2(SCAN_TICKS);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [PER_W-1:0] per_q;
    logic [PER_W-1:0] per_d;
    logic             div_wrap;
    logic             tick_q;
    logic             start_q;

    assign div_wrap = (div_q == DIV_W'(TICK_DIV - 1));

    // per_q holds the count of the tick currently being strobed; it advances after that strobe
    always_comb begin
        div_d = div_wrap ? '0 : div_q + DIV_W'(1);
        per_d = per_q;
        if (tick_q) begin
            per_d = (per_q == PER_W'(SCAN_TICKS - 1)) ? '0 : per_q + PER_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_q   <= '0;
            per_q   <= '0;
            tick_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            per_q   <= per_d;
            tick_q  <= div_wrap;
            start_q <= div_wrap && (per_q == '0);
        end
    end

    assign o_tick       = tick_q;
    assign o_scan_start = start_q;

endmodule

// File: rtl/jpd_pad_scan.sv
// Scans one NES controller plus two turbo keys and publishes a two-scan-filtered
// pressed=1 button vector.
module jpd_pad_scan
    import jpd_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 108,
    parameter int unsigned SCAN_TICKS = 2778
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_scan_en,
    output logic                 o_pad_latch,
    output logic                 o_pad_clk,
    input  logic                 i_pad_data_n,
    input  logic                 i_tb_a_n,
    input  logic                 i_tb_b_n,
    output logic [JPD_VEC_W-1:0] o_jp_vec,
    output logic                 o_scan_done
);

    logic tick;
    logic scan_start;

    jpd_tick_gen #(
        .TICK_DIV   (TICK_DIV),
        .SCAN_TICKS (SCAN_TICKS)
    ) u_tick_gen (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .o_tick       (tick),
        .o_scan_start (scan_start)
    );

    // Two-flop synchronisers; reset to the released (high) level of the active-low inputs
    logic [2:0] meta_q;
    logic [2:0] sync_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_q <= 3'b111;
            sync_q <= 3'b111;
        end else begin
            meta_q <= {i_tb_b_n, i_tb_a_n, i_pad_data_n};
            sync_q <= meta_q;
        end
    end

    logic data_n_s;
    logic tb_a_n_s;
    logic tb_b_n_s;

    assign data_n_s = sync_q[0];
    assign tb_a_n_s = sync_q[1];
    assign tb_b_n_s = sync_q[2];

    jpd_state_e           state_q;
    logic [JPD_BIT_W-1:0] bit_q;
    logic [JPD_VEC_W-1:0] raw_q;
    logic [JPD_VEC_W-1:0] prev_q;
    logic [JPD_VEC_W-1:0] vec_q;
    logic                 latch_q;
    logic                 pclk_q;
    logic                 done_q;

    // Every state but CMP advances on the tick; data is sampled on the tick that leaves S0/HI
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            bit_q   <= '0;
            raw_q   <= '0;
            prev_q  <= '0;
            vec_q   <= '0;
            latch_q <= 1'b0;
            pclk_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tick && scan_start && i_scan_en) begin
                        latch_q <= 1'b1;
                        state_q <= LATCH0;
                    end
                end
                LATCH0: begin
                    if (tick) begin
                        state_q <= LATCH1;
                    end
                end
                LATCH1: begin
                    if (tick) begin
                        latch_q <= 1'b0;
                        state_q <= S0;
                    end
                end
                S0: begin
                    if (tick) begin
                        raw_q[JPD_A]    <= ~data_n_s;
                        raw_q[JPD_TB_A] <= ~tb_a_n_s;
                        raw_q[JPD_TB_B] <= ~tb_b_n_s;
                        bit_q           <= JPD_BIT_W'(1);
                        pclk_q          <= 1'b0;
                        state_q         <= LO;
                    end
                end
                LO: begin
                    if (tick) begin
                        pclk_q  <= 1'b1;
                        state_q <= HI;
                    end
                end
                HI: begin
                    if (tick) begin
                        raw_q[bit_q] <= ~data_n_s;
                        if (bit_q == JPD_BIT_W'(JPD_RIGHT)) begin
                            state_q <= CMP;
                        end else begin
                            bit_q   <= bit_q + JPD_BIT_W'(1);
                            pclk_q  <= 1'b0;
                            state_q <= LO;
                        end
                    end
                end
                CMP: begin
                    if (raw_q == prev_q) begin
                        vec_q <= raw_q;
                    end
                    prev_q  <= raw_q;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_pad_latch = latch_q;
    assign o_pad_clk   = pclk_q;
    assign o_jp_vec    = vec_q;
    assign o_scan_done = done_q;

endmodule

// File: tb/tb_jpd_pad_scan.sv
// Self-checking bench: NES pad model, cycle-level behavioural reference, directed and random scans.
module tb_jpd_pad_scan;

    localparam int TD   = 4;
    localparam int ST   = 20;
    localparam int P    = TD * ST;
    localparam int SCAN = 17;

    logic       clk;
    logic       rst;
    logic       scan_en;
    logic       pad_data_n;
    logic       tb_a_n;
    logic       tb_b_n;
    logic       latch;
    logic       pclk;
    logic       done;
    logic [9:0] vec;

    logic [7:0] btn;
    logic       pad_present;
    logic [7:0] sh;

    int n;
    int total;
    int bad;

    // model state
    logic [9:0] prev_m;
    logic [9:0] exp_m;
    logic [9:0] raw_m;
    logic       act;
    int         ph;
    int         tk;
    logic       el;
    logic       ec;
    logic       ed;

    // stimulus scratch
    int   cnt;
    int   c;
    int   lows;
    int   lowcyc;
    logic prevc;

    jpd_pad_scan #(
        .TICK_DIV   (TD),
        .SCAN_TICKS (ST)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_scan_en    (scan_en),
        .o_pad_latch  (latch),
        .o_pad_clk    (pclk),
        .i_pad_data_n (pad_data_n),
        .i_tb_a_n     (tb_a_n),
        .i_tb_b_n     (tb_b_n),
        .o_jp_vec     (vec),
        .o_scan_done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // posedges seen since reset release
    always @(posedge clk or posedge rst) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    // 4021-style pad: parallel load while latched, shift on rising clock, zeros fill in
    always @(posedge pclk or posedge latch) begin
        if (latch) sh <= btn;
        else       sh <= {1'b0, sh[7:1]};
    end
    assign pad_data_n = pad_present ? ~sh[0] : 1'b1;

    function automatic int phase(input int nn);
        if (nn - 1 - TD < 0) return -1;
        return (nn - 1 - TD) % P;
    endfunction

    function automatic logic [9:0] sample_raw();
        return {~tb_b_n, ~tb_a_n, (pad_present ? btn : 8'h00)};
    endfunction

    task automatic chk(input string nm, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic step_in();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 3 * P);
        if (!done) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic wait_latch(input string nm);
        int k;
        k = 0;
        while (!latch && k < 3 * P) begin
            @(negedge clk);
            k++;
        end
        if (!latch) chk({nm, "_timeout"}, 0, 1);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        scan_en = 1'b1;
        btn = 8'h00;
        pad_present = 1'b1;
        tb_a_n = 1'b1;
        tb_b_n = 1'b1;
        prev_m = '0;
        exp_m = '0;
        raw_m = '0;
        act = 1'b0;
        fork
            begin : cmp
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        prev_m = '0;
                        exp_m  = '0;
                        act    = 1'b0;
                    end else begin
                        ph = phase(n);
                        el = 1'b0;
                        ec = 1'b1;
                        ed = 1'b0;
                        if (act && ph >= 0 && ph < SCAN * TD) begin
                            tk = ph / TD;
                            el = (tk < 2);
                            ec = (tk < 3) || (tk % 2 == 0);
                        end
                        if (act && ph == SCAN * TD + 1) begin
                            ed = 1'b1;
                            if (raw_m == prev_m) exp_m = raw_m;
                            prev_m = raw_m;
                        end
                        chk("latch", int'(latch), int'(el));
                        chk("pad_clk", int'(pclk), int'(ec));
                        chk("scan_done", int'(done), int'(ed));
                        chk("jp_vec", int'(vec), int'(exp_m));
                        if (phase(n + 1) == 0) begin
                            act   = scan_en;
                            raw_m = sample_raw();
                        end
                    end
                end
            end
            begin : stim
                repeat (3) @(negedge clk);
                chk("rst_latch", int'(latch), 0);
                chk("rst_pad_clk", int'(pclk), 1);
                chk("rst_vec", int'(vec), 0);
                chk("rst_done", int'(done), 0);
                step_in();
                rst = 1'b0;

                // scan waveform shape
                wait_latch("first_latch");
                cnt = 0;
                while (latch && cnt < 100) begin
                    cnt++;
                    @(negedge clk);
                end
                chk("latch_cycles", cnt, 8);
                lows = 0;
                lowcyc = 0;
                prevc = 1'b1;
                c = 0;
                while (!done && c < 200) begin
                    if (!pclk) lowcyc++;
                    if (prevc && !pclk) lows++;
                    prevc = pclk;
                    @(negedge clk);
                    c++;
                end
                chk("clk_pulses", lows, 7);
                chk("clk_low_cycles", lowcyc, 28);
                chk("vec_released", int'(vec), 0);
                c = 0;
                do begin
                    @(negedge clk);
                    c++;
                end while (!done && c < 3 * P);
                chk("done_period", c, 80);

                // single-scan glitch on Start
                step_in(); btn = 8'h08;
                wait_done("glitch1");
                step_in(); btn = 8'h00;
                wait_done("glitch2");
                chk("glitch_vec_a", int'(vec), 0);
                wait_done("glitch3");
                chk("glitch_vec_b", int'(vec), 0);

                // turbo-B held three scans
                step_in(); tb_b_n = 1'b0;
                wait_done("tbb1"); chk("tbb_scan1", int'(vec), 10'h000);
                wait_done("tbb2"); chk("tbb_scan2", int'(vec), 10'h200);
                wait_done("tbb3"); chk("tbb_scan3", int'(vec), 10'h200);
                step_in(); tb_b_n = 1'b1;
                wait_done("tbb4"); chk("tbb_rel1", int'(vec), 10'h200);
                wait_done("tbb5"); chk("tbb_rel2", int'(vec), 10'h000);

                // A + Right
                step_in(); btn = 8'h81;
                wait_done("ar1"); chk("ar_scan1", int'(vec), 10'h000);
                wait_done("ar2"); chk("ar_scan2", int'(vec), 10'h081);

                // drop enable during LO3
                wait_latch("en_latch");
                repeat (29) @(posedge clk);
                #2 scan_en = 1'b0;
                wait_done("en_finish");
                chk("en_vec_after", int'(vec), 10'h081);
                cnt = 0;
                c = 0;
                repeat (3 * P + 20) begin
                    @(negedge clk);
                    if (done) cnt++;
                    if (latch || !pclk) c++;
                end
                chk("en_off_scans", cnt, 0);
                chk("en_off_activity", c, 0);
                chk("en_off_vec", int'(vec), 10'h081);
                step_in(); scan_en = 1'b1;
                wait_done("en_back");
                chk("en_back_vec", int'(vec), 10'h081);

                // reset in HI5
                wait_latch("rst_latch_wait");
                chk("vec_before_reset", int'(vec), 10'h081);
                repeat (49) @(posedge clk);
                #2 rst = 1'b1;
                #1;
                chk("midrst_latch", int'(latch), 0);
                chk("midrst_pad_clk", int'(pclk), 1);
                chk("midrst_vec", int'(vec), 0);
                repeat (2) @(posedge clk);
                #2 rst = 1'b0;
                wait_latch("post_rst_latch");
                cnt = 0;
                while (latch && cnt < 100) begin
                    cnt++;
                    @(negedge clk);
                end
                chk("post_rst_latch_cycles", cnt, 8);
                wait_done("prs1"); chk("post_rst_scan1", int'(vec), 10'h000);
                wait_done("prs2"); chk("post_rst_scan2", int'(vec), 10'h081);

                // unplugged pad
                step_in(); pad_present = 1'b0; btn = 8'hff;
                wait_done("miss1"); chk("missing_scan1", int'(vec), 10'h081);
                wait_done("miss2"); chk("missing_scan2", int'(vec), 10'h000);

                // randomized scans
                for (int i = 0; i < 40; i++) begin
                    step_in();
                    if ($urandom_range(1, 0) == 0) begin
                        btn    = 8'($urandom);
                        tb_a_n = 1'($urandom);
                        tb_b_n = 1'($urandom);
                        pad_present = ($urandom_range(7, 0) != 0);
                    end
                    if ($urandom_range(9, 0) == 0) begin
                        scan_en = 1'b0;
                        repeat ($urandom_range(250, 50)) @(posedge clk);
                        #2 scan_en = 1'b1;
                    end
                    wait_done("rand");
                end
            end
        join_any
        disable fork;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
